fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the instruction-fetch stage. Drives the PC register enable, the PC-source select and the IF/ID, ID/EX bubble controls.
//  Covers reset warm-up, load-use stalls, branch redirects (extra bubbles for synchronous i_mem latency) and debug halt.
//  Keeps saturating stall/flush performance counters. Sits between EX-stage resolution and if_stage / pipeline registers.
// PARAMETERS
//  BOOT_CYCLES       4   cycles pc_en held low after reset release (>=1)
//  REDIRECT_BUBBLES  1   extra IF/ID flush cycles after a taken branch (0..7)
//  CNT_W             32  width of perf counters
// PORTS
//  clk              in   1      clock, rising edge
//  rst              in   1      asynchronous, active-low reset
//  id_valid         in   1      ID holds a real instruction
//  id_rs1, id_rs2   in   5      ID source registers
//  id_uses_rs1/rs2  in   1      ID instruction reads rs1 / rs2
//  ex_memread       in   1      EX instruction is a load
//  ex_rd            in   5      EX destination register
//  ex_branch_taken  in   1      EX resolved taken branch/jump (target on pc_branch)
//  halt_req         in   1      debug halt request, level
//  pc_en            out  1      PC register enable (if_stage en)
//  pcsrc            out  1      select pc_branch (if_stage pcsrc)
//  ifid_en          out  1      IF/ID register enable
//  ifid_flush       out  1      IF/ID load bubble
//  idex_flush       out  1      ID/EX load bubble
//  halt_ack         out  1      core halted, fetch frozen
//  stall_cnt        out  CNT_W  load-use stall cycles, saturating
//  flush_cnt        out  CNT_W  taken-branch redirects, saturating
// BEHAVIOUR
//  States: BOOT, RUN, REDIRECT, HALTED. Reset (rst=0) -> BOOT immediately, any cycle; counters cleared.
//  Reset outputs: pc_en=0 pcsrc=0 ifid_en=0 ifid_flush=1 idex_flush=1 halt_ack=0 stall_cnt=0 flush_cnt=0.
//  Outputs are combinational from state + inputs (Mealy); registered state only.
//  BOOT: down-counter loaded BOOT_CYCLES-1 at reset; pc_en=0, ifid_flush=1, idex_flush=1.
//    At count 0 -> RUN next edge; first PC increment on exactly BOOT_CYCLES-th edge after rst rises.
//  RUN, priority high->low:
//   1 ex_branch_taken: pcsrc=1 pc_en=1 ifid_flush=1 idex_flush=1, flush_cnt+1.
//     REDIRECT_BUBBLES>0 -> REDIRECT, bubble counter=REDIRECT_BUBBLES-1; else stay RUN.
//     Overrides load-use (ID is wrong path) and defers halt.
//   2 load-use: id_valid & ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//     pc_en=0 ifid_en=0 idex_flush=1, stall_cnt+1. One cycle; no state change.
//   3 halt_req: -> HALTED next edge; this cycle is normal run.
//   4 default: pc_en=1 ifid_en=1, all flushes 0, pcsrc=0.
//  REDIRECT: pc_en=1 pcsrc=0 ifid_en=1 ifid_flush=1 idex_flush=0; load-use check disabled.
//    Counter 0 -> RUN, or HALTED if halt_req. ex_branch_taken here restarts the redirect as in RUN (flush_cnt+1).
//  HALTED: pc_en=0 ifid_en=0 idex_flush=1 halt_ack=1. halt_req=0 -> RUN next edge, halt_ack drops same edge.
//  Counters: +1 per qualifying cycle, stick at 2^CNT_W-1, never wrap. Both may not increment same cycle (priority).
//  pcsrc is 1 only in the branch-taken cycle; never 1 while pc_en=0.
// STRUCTURE
//  fetch_ctrl_defs.vh: state encodings (ST_BOOT, ST_RUN, ST_REDIRECT, ST_HALTED), REG_ZERO=5'd0.
//  Sub-module sat_counter (param W; inc, clear, async active-low rst) instanced for stall_cnt and flush_cnt.
//  Hazard comparator and FSM stay inline.
// TESTING
//  1 Reset release, BOOT_CYCLES=4: pc_en=0 for cycles 0-3, pc_en=1 cycle 4; ifid_flush=1 until RUN.
//  2 ex_memread=1 ex_rd=5 id_rs1=5 id_uses_rs1=1 -> 1 cycle pc_en=0 ifid_en=0 idex_flush=1, stall_cnt 0->1.
//    Same with ex_rd=0 -> no stall.
//  3 ex_branch_taken 1 cycle, REDIRECT_BUBBLES=1 -> cycle0 pcsrc=1 both flushes; cycle1 ifid_flush=1 pcsrc=0; cycle2 RUN; flush_cnt=1.
//  4 Branch + load-use same cycle -> redirect only, stall_cnt unchanged. Branch + halt_req -> redirect completes, then halt_ack=1.
//  5 halt_req high 10 cycles -> halt_ack=1, pc_en=0 throughout; drop -> pc_en=1 next cycle. rst=0 mid-REDIRECT -> reset values at once.
//  6 CNT_W=4, 20 stalls -> stall_cnt holds at 15.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_REDIRECT,
    ST_HALTED
  } fetch_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when the ID instruction actually reads a source that matches the EX destination.
  function automatic logic reg_hit(input logic uses, input logic [4:0] src, input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Hazard inputs and fetch/pipeline control outputs of the fetch sequencer.
interface fetch_ctrl_if #(
  parameter int CNT_W = 32
) ();

  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_memread;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             halt_req;
  logic             pc_en;
  logic             pcsrc;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halt_ack;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_memread, ex_rd, ex_branch_taken, halt_req,
    output pc_en, pcsrc, ifid_en, ifid_flush, idex_flush, halt_ack,
    output stall_cnt, flush_cnt
  );

  modport slave (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_memread, ex_rd, ex_branch_taken, halt_req,
    input  pc_en, pcsrc, ifid_en, ifid_flush, idex_flush, halt_ack,
    input  stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module fetch_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: boot warm-up, load-use stalls, branch redirects and debug halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES      = 4,
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_ctrl_if.master bus
);

  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LOAD = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [2:0] BUB_LOAD = (REDIRECT_BUBBLES > 0) ? 3'(REDIRECT_BUBBLES - 1) : 3'd0;

  fetch_state_e      state, next_state;
  logic [BOOT_W-1:0] boot_cnt, boot_next;
  logic [2:0]        bub_cnt, bub_next;

  logic load_use;
  logic pc_en, pcsrc, ifid_en, ifid_flush, idex_flush, halt_ack;
  logic stall_inc, flush_inc;

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // An x0 destination never creates a real dependency.
  assign load_use = bus.id_valid && bus.ex_memread && (bus.ex_rd != REG_ZERO) &&
                    (reg_hit(bus.id_uses_rs1, bus.id_rs1, bus.ex_rd) ||
                     reg_hit(bus.id_uses_rs2, bus.id_rs2, bus.ex_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      boot_cnt <= BOOT_LOAD;
      bub_cnt  <= 3'd0;
    end else begin
      state    <= next_state;
      boot_cnt <= boot_next;
      bub_cnt  <= bub_next;
    end
  end

  always_comb begin
    next_state = state;
    boot_next  = boot_cnt;
    bub_next   = bub_cnt;
    pc_en      = 1'b0;
    pcsrc      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halt_ack   = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    case (state)
      ST_BOOT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (boot_cnt == '0) begin
          next_state = ST_RUN;
        end else begin
          boot_next = boot_cnt - 1'b1;
        end
      end

      ST_RUN, ST_REDIRECT: begin
        // A taken branch wins over everything: ID holds wrong-path work and halt waits.
        if (bus.ex_branch_taken) begin
          pc_en      = 1'b1;
          pcsrc      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
          if (REDIRECT_BUBBLES > 0) begin
            next_state = ST_REDIRECT;
            bub_next   = BUB_LOAD;
          end else begin
            next_state = ST_RUN;
          end
        end else if (state == ST_REDIRECT) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          if (bub_cnt == 3'd0) begin
            next_state = bus.halt_req ? ST_HALTED : ST_RUN;
          end else begin
            bub_next = bub_cnt - 3'd1;
          end
        end else if (load_use) begin
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
          if (bus.halt_req) begin
            next_state = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        idex_flush = 1'b1;
        halt_ack   = 1'b1;
        if (!bus.halt_req) begin
          next_state = ST_RUN;
        end
      end

      default: begin
        next_state = ST_BOOT;
      end
    endcase
  end

  fetch_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  fetch_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign bus.pc_en      = pc_en;
  assign bus.pcsrc      = pcsrc;
  assign bus.ifid_en    = ifid_en;
  assign bus.ifid_flush = ifid_flush;
  assign bus.idex_flush = idex_flush;
  assign bus.halt_ack   = halt_ack;
  assign bus.stall_cnt  = stall_cnt;
  assign bus.flush_cnt  = flush_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; 4-bit counters so saturation is reachable quickly.
module tb_fetch_ctrl;

  localparam int CNT_W = 4;

  // Control vector order: {pc_en, pcsrc, ifid_en, ifid_flush, idex_flush, halt_ack}
  localparam logic [5:0] C_BOOT  = 6'b000110;
  localparam logic [5:0] C_RUN   = 6'b101000;
  localparam logic [5:0] C_STALL = 6'b000010;
  localparam logic [5:0] C_BR    = 6'b111110;
  localparam logic [5:0] C_REDIR = 6'b101100;
  localparam logic [5:0] C_HALT  = 6'b000011;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fetch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  fetch_ctrl #(
    .BOOT_CYCLES      (4),
    .REDIRECT_BUBBLES (1),
    .CNT_W            (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic [5:0] expected);
    check_output(tag, {26'd0, bus.pc_en, bus.pcsrc, bus.ifid_en, bus.ifid_flush,
                       bus.idex_flush, bus.halt_ack}, {26'd0, expected});
  endtask

  task automatic check_cnts(input string tag, input int stall_exp, input int flush_exp);
    check_output({tag, "_stall"}, 32'(bus.stall_cnt), stall_exp);
    check_output({tag, "_flush"}, 32'(bus.flush_cnt), flush_exp);
  endtask

  // Waits for the falling edge, then drives the next cycle's inputs.
  task automatic apply_stimulus(input logic valid, input logic [4:0] rs1, input logic uses1,
                                input logic [4:0] rs2, input logic uses2, input logic memread,
                                input logic [4:0] rd, input logic br, input logic halt);
    @(negedge clk);
    bus.id_valid        = valid;
    bus.id_rs1          = rs1;
    bus.id_uses_rs1     = uses1;
    bus.id_rs2          = rs2;
    bus.id_uses_rs2     = uses2;
    bus.ex_memread      = memread;
    bus.ex_rd           = rd;
    bus.ex_branch_taken = br;
    bus.halt_req        = halt;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    bus.id_valid = 1'b0; bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b0;
    bus.id_rs2 = 5'd0; bus.id_uses_rs2 = 1'b0; bus.ex_memread = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_branch_taken = 1'b0; bus.halt_req = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check_ctrl("reset", C_BOOT);
    check_cnts("reset", 0, 0);

    // Boot: cycles 0..3 frozen, cycle 4 running
    idle();
    rst_n = 1'b1;
    #1 check_ctrl("boot_c0", C_BOOT);
    for (int c = 1; c < 4; c++) begin
      idle();
      #1 check_ctrl($sformatf("boot_c%0d", c), C_BOOT);
    end
    idle();
    #1 check_ctrl("boot_c4", C_RUN);

    // Load-use through rs1
    apply_stimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    #1 check_ctrl("lu_rs1", C_STALL);
    check_cnts("lu_rs1_pre", 0, 0);
    idle();
    #1 check_ctrl("lu_after", C_RUN);
    check_cnts("lu_rs1_post", 1, 0);

    // x0 destination is never a hazard
    apply_stimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1 check_ctrl("lu_rd_zero", C_RUN);

    // Load-use through rs2
    apply_stimulus(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    #1 check_ctrl("lu_rs2", C_STALL);

    // Matching rs1 that is not actually read
    apply_stimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
    #1 check_ctrl("lu_unused", C_RUN);

    // Taken branch with one redirect bubble
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1 check_ctrl("br_c0", C_BR);
    idle();
    #1 check_ctrl("br_c1", C_REDIR);
    check_cnts("br_c1", 2, 1);
    idle();
    #1 check_ctrl("br_c2", C_RUN);

    // Branch overrides a simultaneous load-use
    apply_stimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    #1 check_ctrl("br_lu_c0", C_BR);
    idle();
    #1 check_ctrl("br_lu_c1", C_REDIR);
    check_cnts("br_lu", 2, 2);
    idle();
    #1 check_ctrl("br_lu_c2", C_RUN);

    // Branch with halt pending: redirect finishes, then halt
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    #1 check_ctrl("br_halt_c0", C_BR);
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 check_ctrl("br_halt_c1", C_REDIR);
    check_cnts("br_halt", 2, 3);
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 check_ctrl("br_halt_c2", C_HALT);
    idle();
    #1 check_ctrl("br_halt_drop", C_HALT);
    idle();
    #1 check_ctrl("br_halt_resume", C_RUN);

    // Halt held for ten cycles
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 check_ctrl("halt_c0", C_RUN);
    for (int i = 1; i < 10; i++) begin
      apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      #1 check_ctrl($sformatf("halt_c%0d", i), C_HALT);
    end
    idle();
    #1 check_ctrl("halt_drop", C_HALT);
    idle();
    #1 check_ctrl("halt_resume", C_RUN);

    // Twenty stalls saturate the 4-bit stall counter at 15
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      #1 check_ctrl($sformatf("sat_stall%0d", i), C_STALL);
    end
    idle();
    #1 check_ctrl("sat_after", C_RUN);
    check_cnts("sat", 15, 3);

    // Reset asserted in the middle of a redirect
    apply_stimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    #1 check_ctrl("rst_br_c0", C_BR);
    idle();
    #1 check_ctrl("rst_br_c1", C_REDIR);
    #1 rst_n = 1'b0;
    #1 check_ctrl("rst_mid", C_BOOT);
    check_cnts("rst_mid", 0, 0);
    idle();
    #1 check_ctrl("rst_held", C_BOOT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
